// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: two-master / one-slave Wishbone-classic arbiter.
// m0 is the core instruction port and m1 is the data port. Transactions are
// serialised through a registered grant FSM, with round-robin or fixed m1
// priority. Exactly one IDLE cycle separates consecutive transactions.
// Optional feature: define ARBITER_TIMEOUT_EN to add a watchdog that ends a
// hung slave cycle with ack+err after TIMEOUT_CYCLES granted cycles.
module core_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PRIORITY_MODE  = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_M0 = 2'd1,
    ST_GRANT_M1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 1 = m1 served last
  logic   req0_c, req1_c, expire_c;

  assign req0_c = m0_cyc_i & m0_stb_i;
  assign req1_c = m1_cyc_i & m1_stb_i;

  // Read data is broadcast; only the ack qualifies it
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

`ifdef ARBITER_TIMEOUT_EN
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Watchdog: zero in IDLE so every grant starts from 0, counts granted cycles
  always_ff @(posedge clk) begin
    if (!rst_n || state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A real ack in the expiry cycle wins over the timeout
  assign expire_c = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && !s_ack_i;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES < 32'd2);
  assign expire_c       = 1'b0;
`endif

  // State and last-grant registers; after reset m0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: arbitrate in IDLE, release on ack, abandon or timeout
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_c && req1_c) begin
          if ((PRIORITY_MODE != 0) || !last_grant_q) begin
            state_d      = ST_GRANT_M1;
            last_grant_d = 1'b1;
          end else begin
            state_d      = ST_GRANT_M0;
            last_grant_d = 1'b0;
          end
        end else if (req0_c) begin
          state_d      = ST_GRANT_M0;
          last_grant_d = 1'b0;
        end else if (req1_c) begin
          state_d      = ST_GRANT_M1;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT_M0: begin
        if (!m0_cyc_i || s_ack_i || expire_c) state_d = ST_IDLE;
      end
      ST_GRANT_M1: begin
        if (!m1_cyc_i || s_ack_i || expire_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: route the owner to the slave and the slave response to the owner
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state_q)
      ST_GRANT_M0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_addr_o = m0_addr_i;
        s_data_o = m0_data_i;
        m0_ack_o = (s_ack_i | expire_c) & m0_cyc_i;
        m0_err_o = expire_c & m0_cyc_i;
      end
      ST_GRANT_M1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_addr_o = m1_addr_i;
        s_data_o = m1_data_i;
        m1_ack_o = (s_ack_i | expire_c) & m1_cyc_i;
        m1_err_o = expire_c & m1_cyc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: instance a is round-robin, instance b is fixed
// m1 priority. Both use TIMEOUT_CYCLES = 8 (active only with the macro).
module tb_core_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;

  logic [31:0] a_m0_rdat, a_m1_rdat, a_s_addr, a_s_wdat;
  logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err, a_s_cyc, a_s_stb, a_s_we;
  logic [1:0]  a_grant;

  logic        b_m0_req, b_m1_req, b_ack;
  logic [31:0] b_m0_rdat, b_m1_rdat, b_s_addr, b_s_wdat;
  logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err, b_s_cyc, b_s_stb, b_s_we;
  logic [1:0]  b_grant;

  typedef struct {
    int          master;
    logic [31:0] data;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_miss;

  core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(a_m0_rdat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_data_o(a_m1_rdat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_addr_o(a_s_addr), .s_data_o(a_s_wdat),
    .s_data_i(s_rdat), .s_ack_i(s_ack), .grant_o(a_grant)
  );

  core_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(b_m0_req), .m0_stb_i(b_m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(b_m0_rdat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_cyc_i(b_m1_req), .m1_stb_i(b_m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_data_o(b_m1_rdat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_addr_o(b_s_addr), .s_data_o(b_s_wdat),
    .s_data_i(s_rdat), .s_ack_i(b_ack), .grant_o(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next active edge (drive point)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle
  task automatic samp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
    s_ack = 0; s_rdat = '0;
    b_m0_req = 0; b_m1_req = 0; b_ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m0_addr = 32'h55; m1_addr = 32'h66;
    b_m0_req = 1; b_m1_req = 1;
    rst_n = 0;
    tick();
    tick();
    samp();
    n_vec++;
    if (a_grant !== 2'b00 || b_grant !== 2'b00) begin
      n_miss++; $display("FAIL reset_grant: a=%b b=%b expected 00", a_grant, b_grant);
    end
    n_vec++;
    if ({a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err} !== 7'b0) begin
      n_miss++; $display("FAIL reset_ctrl: got %b expected 0000000",
                         {a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err});
    end
    n_vec++;
    if (a_s_addr !== 32'h0 || a_s_wdat !== 32'h0) begin
      n_miss++; $display("FAIL reset_bus: addr=%h data=%h expected 0", a_s_addr, a_s_wdat);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    exp_t e;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h0000_0010;
    samp();
    n_vec++;
    if (a_grant !== 2'b00) begin
      n_miss++; $display("FAIL read_req_cycle: grant=%b expected 00", a_grant);
    end
    tick();
    sb.push_back('{0, 32'h1234_5678, 32'h0000_0010});
    samp();
    n_vec++;
    if (a_grant !== 2'b01 || a_s_cyc !== 1'b1 || a_s_addr !== 32'h10 || a_m0_ack !== 1'b0) begin
      n_miss++; $display("FAIL read_grant: grant=%b cyc=%b addr=%h ack=%b expected 01 1 00000010 0",
                         a_grant, a_s_cyc, a_s_addr, a_m0_ack);
    end
    tick();
    s_ack = 1; s_rdat = 32'h1234_5678;
    samp();
    n_vec++;
    if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin
      n_miss++; $display("FAIL read_ack: m0_ack=%b m1_ack=%b expected 1 0", a_m0_ack, a_m1_ack);
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (a_m0_rdat !== e.data || a_m1_rdat !== e.data || a_s_addr !== e.addr) begin
        n_miss++; $display("FAIL read_data: data=%h/%h addr=%h expected %h %h",
                           a_m0_rdat, a_m1_rdat, a_s_addr, e.data, e.addr);
      end
    end
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    samp();
    n_vec++;
    if (a_grant !== 2'b00 || a_s_cyc !== 1'b0) begin
      n_miss++; $display("FAIL read_idle_after: grant=%b cyc=%b expected 00 0", a_grant, a_s_cyc);
    end
    sb.delete();
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   c0, c1, k, got, last_ack;
    do_reset();
    c0 = 0; c1 = 0; k = 0; last_ack = -1;
    for (int i = 0; i < 8; i++)
      sb.push_back('{i % 2, 32'hA5A5_0000 + 32'(i), (i % 2 == 1) ? 32'h200 + 32'(i / 2) : 32'h100 + 32'(i / 2)});
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    s_ack = 1; s_rdat = 32'hA5A5_0000;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      samp();
      if (a_m0_ack && a_m1_ack) begin
        n_vec++; n_miss++;
        $display("FAIL rr_both_ack: both acks high in cycle %0d, expected one", cyc);
      end else if (a_m0_ack || a_m1_ack) begin
        e = sb.pop_front();
        got = a_m1_ack ? 1 : 0;
        n_vec++;
        if (got != e.master) begin
          n_miss++; $display("FAIL rr_owner: ack on m%0d expected m%0d", got, e.master);
        end
        n_vec++;
        if (a_s_addr !== e.addr || a_m0_rdat !== e.data) begin
          n_miss++; $display("FAIL rr_payload: addr=%h data=%h expected %h %h",
                             a_s_addr, a_m0_rdat, e.addr, e.data);
        end
        if (got == 0) c0++; else c1++;
        k++;
        last_ack = cyc;
      end
      tick();
      m0_addr = 32'h100 + 32'(c0);
      m1_addr = 32'h200 + 32'(c1);
      if (c0 >= 4) begin m0_cyc = 0; m0_stb = 0; end
      if (c1 >= 4) begin m1_cyc = 0; m1_stb = 0; end
      s_rdat = 32'hA5A5_0000 + 32'(k);
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++; $display("FAIL rr_timeout: %0d transfers outstanding expected 0", sb.size());
    end
    n_vec++;
    if (last_ack != 15) begin
      n_miss++; $display("FAIL rr_throughput: last ack in cycle %0d expected 15", last_ack);
    end
    sb.delete();
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    exp_t e;
    int   c0, c1, got;
    do_reset();
    c0 = 0; c1 = 0;
    for (int i = 0; i < 5; i++) sb.push_back('{(i < 4) ? 1 : 0, 32'h0, 32'h0});
    b_m0_req = 1; b_m1_req = 1; b_ack = 1;
    for (int cyc = 0; cyc < 60 && sb.size() > 0; cyc++) begin
      samp();
      if (b_m0_ack || b_m1_ack) begin
        e = sb.pop_front();
        got = b_m1_ack ? 1 : 0;
        n_vec++;
        if (got != e.master || b_grant !== ((e.master == 1) ? 2'b10 : 2'b01) || (b_m0_ack && b_m1_ack)) begin
          n_miss++; $display("FAIL prio_owner: ack m0=%b m1=%b grant=%b expected owner m%0d",
                             b_m0_ack, b_m1_ack, b_grant, e.master);
        end
        n_vec++;
        if (b_m0_err !== 1'b0 || b_m1_err !== 1'b0 || b_s_cyc !== 1'b1) begin
          n_miss++; $display("FAIL prio_ctrl: err=%b%b cyc=%b expected 00 1", b_m0_err, b_m1_err, b_s_cyc);
        end
        if (got == 0) c0++; else c1++;
      end
      tick();
      if (c1 >= 4) b_m1_req = 0;
      if (c0 >= 1) b_m0_req = 0;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++; $display("FAIL prio_timeout: %0d transfers outstanding expected 0", sb.size());
    end
    sb.delete();
    idle_inputs();
  endtask

  task automatic test_wait_while_granted();
    exp_t e;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h40;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h0000_0100; m1_wdat = 32'hCAFE_F00D;
    sb.push_back('{0, 32'h5555_0040, 32'h40});
    sb.push_back('{1, 32'h0, 32'h0000_0100});
    for (int i = 0; i < 3; i++) begin
      samp();
      n_vec++;
      if (a_grant !== 2'b01 || a_s_addr !== 32'h40 || a_m1_ack !== 1'b0) begin
        n_miss++; $display("FAIL wait_hold: grant=%b addr=%h m1_ack=%b expected 01 00000040 0",
                           a_grant, a_s_addr, a_m1_ack);
      end
      tick();
    end
    s_ack = 1; s_rdat = 32'h5555_0040;
    samp();
    e = sb.pop_front();
    n_vec++;
    if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0 || a_m0_rdat !== e.data || a_s_addr !== e.addr) begin
      n_miss++; $display("FAIL wait_m0_ack: ack=%b/%b data=%h addr=%h expected 1/0 %h %h",
                         a_m0_ack, a_m1_ack, a_m0_rdat, a_s_addr, e.data, e.addr);
    end
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    samp();
    n_vec++;
    if (a_grant !== 2'b00 || a_s_cyc !== 1'b0 || a_s_addr !== 32'h0) begin
      n_miss++; $display("FAIL wait_gap: grant=%b cyc=%b addr=%h expected 00 0 0", a_grant, a_s_cyc, a_s_addr);
    end
    tick();
    samp();
    e = sb.pop_front();
    n_vec++;
    if (a_grant !== 2'b10 || a_s_we !== 1'b1 || a_s_wdat !== 32'hCAFE_F00D || a_s_addr !== e.addr) begin
      n_miss++; $display("FAIL wait_m1_grant: grant=%b we=%b data=%h addr=%h expected 10 1 cafef00d %h",
                         a_grant, a_s_we, a_s_wdat, a_s_addr, e.addr);
    end
    tick();
    s_ack = 1;
    samp();
    n_vec++;
    if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0) begin
      n_miss++; $display("FAIL wait_m1_ack: m1_ack=%b m0_ack=%b expected 1 0", a_m1_ack, a_m0_ack);
    end
    tick();
    sb.delete();
    idle_inputs();
  endtask

  task automatic test_hung_slave();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h80;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h180;
`ifdef ARBITER_TIMEOUT_EN
    for (int g = 1; g <= 8; g++) begin
      samp();
      n_vec++;
      if (g < 8 && (a_grant !== 2'b01 || a_m0_ack !== 1'b0 || a_m0_err !== 1'b0)) begin
        n_miss++; $display("FAIL wd_wait: cycle %0d grant=%b ack=%b err=%b expected 01 0 0",
                           g, a_grant, a_m0_ack, a_m0_err);
      end else if (g == 8 && (a_m0_ack !== 1'b1 || a_m0_err !== 1'b1 || a_m1_ack !== 1'b0)) begin
        n_miss++; $display("FAIL wd_expire: ack=%b err=%b m1_ack=%b expected 1 1 0",
                           a_m0_ack, a_m0_err, a_m1_ack);
      end
      tick();
    end
    m0_cyc = 0; m0_stb = 0;
    samp();
    n_vec++;
    if (a_grant !== 2'b00) begin
      n_miss++; $display("FAIL wd_idle: grant=%b expected 00", a_grant);
    end
    tick();
    samp();
    n_vec++;
    if (a_grant !== 2'b10 || a_s_addr !== 32'h180) begin
      n_miss++; $display("FAIL wd_next: grant=%b addr=%h expected 10 00000180", a_grant, a_s_addr);
    end
    tick();
    m1_cyc = 0; m1_stb = 0;
    tick();
    // Ack landing exactly on the expiry cycle must not report an error
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int g = 1; g < 8; g++) tick();
    s_ack = 1;
    samp();
    n_vec++;
    if (a_m0_ack !== 1'b1 || a_m0_err !== 1'b0) begin
      n_miss++; $display("FAIL wd_ack_wins: ack=%b err=%b expected 1 0", a_m0_ack, a_m0_err);
    end
    tick();
`else
    for (int g = 1; g <= 20; g++) begin
      samp();
      n_vec++;
      if (a_grant !== 2'b01 || a_m0_ack !== 1'b0 || a_m0_err !== 1'b0 || a_m1_err !== 1'b0) begin
        n_miss++; $display("FAIL hung_hold: cycle %0d grant=%b ack=%b err=%b%b expected 01 0 00",
                           g, a_grant, a_m0_ack, a_m0_err, a_m1_err);
      end
      tick();
    end
    s_ack = 1;
    samp();
    n_vec++;
    if (a_m0_ack !== 1'b1 || a_m0_err !== 1'b0) begin
      n_miss++; $display("FAIL hung_release: ack=%b err=%b expected 1 0", a_m0_ack, a_m0_err);
    end
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    samp();
    n_vec++;
    if (a_grant !== 2'b10 || a_s_addr !== 32'h180) begin
      n_miss++; $display("FAIL hung_next: grant=%b addr=%h expected 10 00000180", a_grant, a_s_addr);
    end
    tick();
`endif
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h300; m1_wdat = 32'h0BAD_BEEF;
    tick();
    samp();
    n_vec++;
    if (a_grant !== 2'b10) begin
      n_miss++; $display("FAIL rmid_grant: grant=%b expected 10", a_grant);
    end
    tick();
    rst_n = 0;
    samp();
    n_vec++;
    if (a_m1_ack !== 1'b0 || a_m1_err !== 1'b0) begin
      n_miss++; $display("FAIL rmid_noack: ack=%b err=%b expected 0 0", a_m1_ack, a_m1_err);
    end
    tick();
    rst_n = 1;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h30;
    samp();
    n_vec++;
    if ({a_grant, a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack} !== 7'b0 || a_s_addr !== 32'h0 || a_s_wdat !== 32'h0) begin
      n_miss++; $display("FAIL rmid_cleared: ctrl=%b addr=%h data=%h expected 0",
                         {a_grant, a_s_cyc, a_s_stb, a_s_we, a_m0_ack, a_m1_ack}, a_s_addr, a_s_wdat);
    end
    tick();
    samp();
    n_vec++;
    if (a_grant !== 2'b01 || a_s_addr !== 32'h30) begin
      n_miss++; $display("FAIL rmid_tie: grant=%b addr=%h expected 01 00000030", a_grant, a_s_addr);
    end
    tick();
    idle_inputs();
  endtask

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_miss = 0;
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_wait_while_granted();
    test_hung_slave();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
